// File: rtl/lp805x_port_result_mon.sv
// Self-test result monitor: watches the CPU's port-0 exit code, qualifies a stable
// value, runs a watchdog, and latches a sticky pass/fail/timeout verdict with the code.
module lp805x_port_result_mon #(
   parameter logic [7:0]           IDLE_CODE     = 8'hFF,
   parameter logic [7:0]           PASS_CODE     = 8'h7F,
   parameter int                   STABLE_CYCLES = 4,
   parameter int                   TIMEOUT_W     = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT       = TIMEOUT_W'(1000000)
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic [7:0] p0_i,
   input  logic       clr_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       pass_o,
   output logic       fail_o,
   output logic       timeout_o,
   output logic [7:0] code_o
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_QUAL,
      ST_DONE
   } state_e;

   localparam logic [7:0]           STAB_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] WD_ONE    = TIMEOUT_W'(1);
   localparam logic [TIMEOUT_W-1:0] WD_LAST   = TIMEOUT - WD_ONE;
   localparam logic [TIMEOUT_W-1:0] WD_MAX    = '1;

   state_e               state_q, state_d;
   logic [7:0]           p0_q;
   logic [7:0]           cand_q, cand_d;
   logic [7:0]           stab_q, stab_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic                 timeout_q, timeout_d;
   logic [7:0]           code_q, code_d;

   logic [TIMEOUT_W-1:0] wdInc;
   logic                 wdExpired;
   logic                 codeStable;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_RUN;
         p0_q      <= IDLE_CODE;
         cand_q    <= 8'h00;
         stab_q    <= 8'h00;
         wd_q      <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         code_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         p0_q      <= p0_i;
         cand_q    <= cand_d;
         stab_q    <= stab_d;
         wd_q      <= wd_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
         code_q    <= code_d;
      end
   end

   assign wdInc      = (wd_q == WD_MAX) ? wd_q : wd_q + WD_ONE;
   assign wdExpired  = (wd_q == WD_LAST);
   assign codeStable = (p0_q == cand_q) && (stab_q == STAB_LAST);

   // A completing qualification beats a watchdog expiry on the same edge; clear beats both.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      stab_d    = stab_q;
      wd_d      = wd_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;
      code_d    = code_q;
      if (clr_i) begin
         state_d   = ST_RUN;
         cand_d    = 8'h00;
         stab_d    = 8'h00;
         wd_d      = '0;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
         timeout_d = 1'b0;
         code_d    = 8'h00;
      end else begin
         case (state_q)
            ST_RUN: begin
               wd_d = wdInc;
               if (wdExpired) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
                  code_d    = 8'h00;
               end else if (p0_q != IDLE_CODE) begin
                  state_d = ST_QUAL;
                  cand_d  = p0_q;
                  stab_d  = 8'h01;
               end
            end
            ST_QUAL: begin
               wd_d = wdInc;
               if (codeStable) begin
                  state_d = ST_DONE;
                  code_d  = cand_q;
                  pass_d  = (cand_q == PASS_CODE);
                  fail_d  = (cand_q != PASS_CODE);
               end else if (wdExpired) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
                  code_d    = 8'h00;
               end else if (p0_q == cand_q) begin
                  stab_d = stab_q + 8'h01;
               end else if (p0_q == IDLE_CODE) begin
                  state_d = ST_RUN;
                  stab_d  = 8'h00;
               end else begin
                  cand_d = p0_q;
                  stab_d = 8'h01;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy_o    = (state_q != ST_DONE);
   assign done_o    = (state_q == ST_DONE);
   assign pass_o    = pass_q;
   assign fail_o    = fail_q;
   assign timeout_o = timeout_q;
   assign code_o    = code_q;

endmodule

// File: tb/tb_lp805x_port_result_mon.sv
// Bench for the port-0 result monitor: a run-length/elapsed-time model checked every
// cycle, plus directed scenarios with hand-counted edge expectations.
module tb_lp805x_port_result_mon;

   localparam logic [7:0]  IDLE      = 8'hFF;
   localparam logic [7:0]  PASS      = 8'h7F;
   localparam int          STABLE    = 4;
   localparam int          TO_CYCLES = 20;

   logic       wbClk = 1'b0;
   logic       wbRst = 1'b1;
   logic [7:0] p0 = IDLE;
   logic       clr = 1'b0;
   logic       busy, done, pass, fail, timeout;
   logic [7:0] code;

   int errors = 0;
   int checks = 0;

   lp805x_port_result_mon #(
      .IDLE_CODE    (IDLE),
      .PASS_CODE    (PASS),
      .STABLE_CYCLES(STABLE),
      .TIMEOUT_W    (24),
      .TIMEOUT      (24'd20)
   ) dut (
      .wb_clk_i (wbClk),
      .wb_rst_i (wbRst),
      .p0_i     (p0),
      .clr_i    (clr),
      .busy_o   (busy),
      .done_o   (done),
      .pass_o   (pass),
      .fail_o   (fail),
      .timeout_o(timeout),
      .code_o   (code)
   );

   always #5 wbClk = ~wbClk;

   // Model: count consecutive decision edges seeing one non-idle value, and edges spent undecided.
   logic [7:0] mP0q, mLast, mCode;
   int         mRun, mElapsed;
   logic       mDone, mPass, mFail, mTo;
   int         nextRun, nextElapsed;

   assign nextRun     = (mP0q == IDLE) ? 0 : ((mP0q == mLast) ? mRun + 1 : 1);
   assign nextElapsed = mElapsed + 1;

   always @(posedge wbClk or posedge wbRst) begin
      if (wbRst) begin
         mP0q <= IDLE; mLast <= 8'h00; mRun <= 0; mElapsed <= 0;
         mDone <= 1'b0; mPass <= 1'b0; mFail <= 1'b0; mTo <= 1'b0; mCode <= 8'h00;
      end else begin
         mP0q <= p0;
         if (clr) begin
            mLast <= 8'h00; mRun <= 0; mElapsed <= 0;
            mDone <= 1'b0; mPass <= 1'b0; mFail <= 1'b0; mTo <= 1'b0; mCode <= 8'h00;
         end else if (!mDone) begin
            mRun     <= nextRun;
            mLast    <= mP0q;
            mElapsed <= nextElapsed;
            if (nextRun == STABLE) begin
               mDone <= 1'b1;
               mCode <= mP0q;
               mPass <= (mP0q == PASS);
               mFail <= (mP0q != PASS);
            end else if (nextElapsed == TO_CYCLES) begin
               mDone <= 1'b1;
               mTo   <= 1'b1;
               mCode <= 8'h00;
            end
         end
      end
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge wbClk) begin
      checks = checks + 1;
      if ({busy, done, pass, fail, timeout, code} !== {!mDone, mDone, mPass, mFail, mTo, mCode}) begin
         errors = errors + 1;
         $display("[TB] FAIL model t=%0t got busy=%b done=%b pass=%b fail=%b to=%b code=%h want busy=%b done=%b pass=%b fail=%b to=%b code=%h",
                  $time, busy, done, pass, fail, timeout, code, !mDone, mDone, mPass, mFail, mTo, mCode);
      end
   end

   task automatic checkOutput(input string name, input logic eBusy, input logic eDone,
                              input logic ePass, input logic eFail, input logic eTo,
                              input logic [7:0] eCode);
      checks = checks + 1;
      if ({busy, done, pass, fail, timeout, code} !== {eBusy, eDone, ePass, eFail, eTo, eCode}) begin
         errors = errors + 1;
         $display("[TB] FAIL %s got busy=%b done=%b pass=%b fail=%b to=%b code=%h want busy=%b done=%b pass=%b fail=%b to=%b code=%h",
                  name, busy, done, pass, fail, timeout, code, eBusy, eDone, ePass, eFail, eTo, eCode);
      end
   endtask

   // Drive a port value and let the given number of rising edges sample it.
   task automatic applyStimulus(input logic [7:0] val, input int edges);
      p0 = val;
      repeat (edges) @(negedge wbClk);
   endtask

   task automatic doReset(input logic [7:0] val);
      p0    = val;
      clr   = 1'b0;
      wbRst = 1'b1;
      @(negedge wbClk);
      @(negedge wbClk);
      wbRst = 1'b0;
   endtask

   initial begin
      #100000;
      errors = errors + 1;
      $display("[TB] FAIL watchdog: bench did not finish in time");
      $fatal(1, "[TB] bench timeout");
   end

   initial begin
      doReset(IDLE);
      checkOutput("reset", 1, 0, 0, 0, 0, 8'h00);

      $display("[TB] pass path");
      applyStimulus(IDLE, 10);
      applyStimulus(PASS, 4);
      checkOutput("pass_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(PASS, 1);
      checkOutput("pass_done", 0, 1, 1, 0, 0, 8'h7F);

      $display("[TB] fail path");
      doReset(8'h03);
      applyStimulus(8'h03, 4);
      checkOutput("fail_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(8'h03, 1);
      checkOutput("fail_done", 0, 1, 0, 1, 0, 8'h03);

      $display("[TB] glitch rejection");
      doReset(IDLE);
      applyStimulus(PASS, 2);
      applyStimulus(IDLE, 5);
      checkOutput("glitch_idle", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(PASS, 2);
      applyStimulus(8'h05, 4);
      checkOutput("glitch_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(8'h05, 1);
      checkOutput("glitch_done", 0, 1, 0, 1, 0, 8'h05);

      $display("[TB] timeout");
      doReset(IDLE);
      applyStimulus(IDLE, 19);
      checkOutput("to_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(IDLE, 1);
      checkOutput("to_done", 0, 1, 0, 0, 1, 8'h00);

      $display("[TB] timeout tie");
      doReset(IDLE);
      applyStimulus(IDLE, 15);
      applyStimulus(PASS, 4);
      checkOutput("tie_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(PASS, 1);
      checkOutput("tie_done", 0, 1, 1, 0, 0, 8'h7F);

      $display("[TB] sticky and clear");
      applyStimulus(8'h09, 6);
      checkOutput("sticky", 0, 1, 1, 0, 0, 8'h7F);
      clr = 1'b1;
      applyStimulus(8'h09, 1);
      clr = 1'b0;
      checkOutput("clr", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(8'h09, 3);
      checkOutput("clr_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(8'h09, 1);
      checkOutput("clr_fail", 0, 1, 0, 1, 0, 8'h09);

      $display("[TB] async reset");
      #2 wbRst = 1'b1;
      #1 checkOutput("rst_from_done", 1, 0, 0, 0, 0, 8'h00);
      @(negedge wbClk);
      wbRst = 1'b0;
      applyStimulus(PASS, 3);
      checkOutput("midqual", 1, 0, 0, 0, 0, 8'h00);
      #2 wbRst = 1'b1;
      #1 checkOutput("rst_midqual", 1, 0, 0, 0, 0, 8'h00);
      #1 wbRst = 1'b0;
      applyStimulus(PASS, 4);
      checkOutput("after_rst_early", 1, 0, 0, 0, 0, 8'h00);
      applyStimulus(PASS, 1);
      checkOutput("after_rst_done", 0, 1, 1, 0, 0, 8'h7F);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lp805x_port_result_mon.md
Name: lp805x_port_result_mon

Overview:
- Synthesizable self-test result monitor: the reading end of the CPU's port-0 exit-code protocol.
- The core writes exit codes to P0: 8'hFF = idle/running, 8'h7F = pass, any other value = fail code.
- This block samples the CPU's P0 output, qualifies a stable code, enforces a run-time watchdog, and latches pass/fail/timeout flags with the exit code.
- Sits beside lp805x_top on FPGA/silicon so tests run without a simulator; outputs drive LEDs or a status register.

Parameters:
- IDLE_CODE, 8'hFF, P0 value meaning "test still running".
- PASS_CODE, 8'h7F, P0 value meaning "test passed".
- STABLE_CYCLES, 4, consecutive identical non-idle samples needed to accept a code; legal range 2..255.
- TIMEOUT_W, 24, watchdog counter width.
- TIMEOUT, 24'd1000000, cycles allowed in RUN/QUAL before a timeout verdict; legal range 1..2^TIMEOUT_W-1.

Ports:
- wb_clk_i  input  1  system clock; the only clock.
- wb_rst_i  input  1  asynchronous, active-high reset.
- p0_i  input  8  CPU port-0 output (lp805x_top p0_o), synchronous to wb_clk_i.
- clr_i  input  1  synchronous clear/restart, active-high.
- busy_o  output  1  high in RUN or QUAL.
- done_o  output  1  high in DONE (sticky).
- pass_o  output  1  accepted code == PASS_CODE.
- fail_o  output  1  accepted code is neither PASS_CODE nor IDLE_CODE.
- timeout_o  output  1  watchdog expired before a code was accepted.
- code_o  output  8  accepted exit code; 8'h00 on timeout.

Behaviour:
- Async reset: state=RUN, p0_q=IDLE_CODE, cand=0, stab_cnt=0, wd_cnt=0. Outputs: busy_o=1, done_o=pass_o=fail_o=timeout_o=0, code_o=8'h00. Reset asserted mid-operation aborts immediately with the same values.
- Input stage: p0_q <= p0_i every edge. All decisions use p0_q only, adding 1 cycle of latency.
- States: RUN, QUAL, DONE. All outputs are registered or decoded directly from state.
- RUN:
  - wd_cnt increments each edge.
  - If p0_q != IDLE_CODE: go to QUAL, cand <= p0_q, stab_cnt <= 1.
- QUAL:
  - wd_cnt increments each edge.
  - p0_q == cand and stab_cnt == STABLE_CYCLES-1: go to DONE, code_o <= cand, pass_o <= (cand==PASS_CODE), fail_o <= !(cand==PASS_CODE).
  - p0_q == cand otherwise: stab_cnt++.
  - p0_q == IDLE_CODE: return to RUN, stab_cnt <= 0.
  - p0_q is another non-idle value: stay in QUAL, cand <= p0_q, stab_cnt <= 1 (restart qualification).
- Latency: p0_i = V (non-idle), first sampled at edge 1 and held through edge STABLE_CYCLES, gives done_o high after edge STABLE_CYCLES+1. With the default this is edge 5.
- Watchdog:
  - In RUN/QUAL, when wd_cnt == TIMEOUT-1 at an edge, go to DONE with timeout_o=1, code_o=8'h00, pass_o=fail_o=0.
  - wd_cnt saturates and never wraps.
- Simultaneous qualification completion and watchdog expiry on the same edge: qualification wins; timeout_o stays 0.
- DONE is sticky: p0_i changes are ignored, flags hold, and the watchdog is frozen.
- clr_i (any state) forces RUN on the next edge: flags cleared, code_o=0, stab_cnt=0, wd_cnt=0, cand=0. p0_q still loads p0_i. clr_i takes priority over all other transitions on that edge.
- Invariants:
  - At most one of pass_o/fail_o/timeout_o is high.
  - done_o == (pass_o | fail_o | timeout_o).
  - busy_o == !done_o.

Test Plan:
- Pass path: reset, p0_i=8'hFF for 10 cycles, then 8'h7F held. Required: done_o=1 and pass_o=1 exactly after the 5th edge following the first 7F sample; code_o=8'h7F; busy_o=0.
- Fail path: p0_i=8'h03 held. Required: fail_o=1, code_o=8'h03, pass_o=0, timeout_o=0.
- Glitch rejection: p0_i=8'h7F for 2 cycles, then 8'hFF for 5 cycles. Required: no done_o and state back to RUN. Then p0_i=8'h7F, 8'h7F, 8'h05 then 8'h05 held. Required: only 05 accepted (fail_o=1, code_o=8'h05) after 4 samples of 05.
- Timeout: TIMEOUT=20, p0_i stays 8'hFF. Required: timeout_o=1 and done_o=1 after edge 20, code_o=8'h00. Tie case: 8'h7F arranged to complete qualification on edge 20. Required: pass_o=1, timeout_o=0.
- Sticky and clear: after a pass, drive p0_i=8'h09. Required: pass_o stays 1. Then pulse clr_i for 1 cycle. Required: all flags 0 and busy_o=1 next cycle; 09 held afterwards gives fail_o=1, code_o=8'h09.
- Async reset mid-QUAL: assert wb_rst_i between edges while stab_cnt=2. Required: outputs at reset values immediately without a clock edge; after release, a new 7F sequence still needs the full 4 samples.
